// File: rtl/bf_pkg.sv
// Shared opcode bytes, FSM state encoding and fault codes for the Brainfuck core.
package bf_pkg;

  localparam logic [7:0] OpInc   = 8'h2B;
  localparam logic [7:0] OpDec   = 8'h2D;
  localparam logic [7:0] OpRight = 8'h3E;
  localparam logic [7:0] OpLeft  = 8'h3C;
  localparam logic [7:0] OpOut   = 8'h2E;
  localparam logic [7:0] OpIn    = 8'h2C;
  localparam logic [7:0] OpOpen  = 8'h5B;
  localparam logic [7:0] OpClose = 8'h5D;
  localparam logic [7:0] OpEnd   = 8'h00;

  typedef enum logic [3:0] {
    StIdle,
    StClear,
    StFetch,
    StExec,
    StWb,
    StRd,
    StIn,
    StOut,
    StSkip,
    StFlush,
    StHalt
  } state_e;

  typedef enum logic [2:0] {
    FaultNone      = 3'd0,
    FaultOverflow  = 3'd1,
    FaultUnderflow = 3'd2,
    FaultPtr       = 3'd3,
    FaultUnmatched = 3'd4
  } fault_e;

endpackage

// File: rtl/bf_loop_stack.sv
// Loop return-address stack: LIFO of 2^SDEPTH program addresses.
module bf_loop_stack #(
  parameter int unsigned SDEPTH = 4,
  parameter int unsigned PWIDTH = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              push,
  input  logic              pop,
  input  logic [PWIDTH-1:0] din,
  output logic [PWIDTH-1:0] top,
  output logic              full,
  output logic              empty
);

  localparam int unsigned     Entries = 2 ** SDEPTH;
  localparam logic [SDEPTH:0] SpOne   = 1;
  localparam logic [SDEPTH:0] SpFull  = {1'b1, {SDEPTH{1'b0}}};

  logic [PWIDTH-1:0] mem_q [Entries];
  logic [SDEPTH:0]   sp_q, sp_d;
  logic [SDEPTH:0]   sp_m1;

  assign full  = (sp_q == SpFull);
  assign empty = (sp_q == '0);
  assign sp_m1 = sp_q - SpOne;
  assign top   = mem_q[sp_m1[SDEPTH-1:0]];

  always_comb begin
    sp_d = sp_q;
    if (clr) begin
      sp_d = '0;
    end else if (push && !full) begin
      sp_d = sp_q + SpOne;
    end else if (pop && !empty) begin
      sp_d = sp_q - SpOne;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sp_q <= '0;
    end else begin
      sp_q <= sp_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full && !clr) begin
      mem_q[sp_q[SDEPTH-1:0]] <= din;
    end
  end

  assert property (@(posedge clk) disable iff (!rst) !(push && pop));

endmodule

// File: rtl/bf_core_v2.sv
// Brainfuck execution core: fetch/execute FSM with a single-cell write-back cache,
// valid/ready stalls on program, data and byte streams, and fault reporting.
module bf_core_v2 #(
  parameter int unsigned AWIDTH    = 12,
  parameter int unsigned DWIDTH    = 8,
  parameter int unsigned PWIDTH    = 12,
  parameter int unsigned SDEPTH    = 4,
  parameter int unsigned CELL_MODE = 0,
  parameter int unsigned PTR_MODE  = 0,
  parameter int unsigned CLEAR_EN  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_rst,
  input  logic              start,
  output logic [PWIDTH-1:0] pc,
  output logic              op_req,
  input  logic [7:0]        op_data,
  input  logic              op_valid,
  output logic [AWIDTH-1:0] dp_adr,
  output logic              mem_we,
  output logic [DWIDTH-1:0] mem_wdata,
  output logic              mem_re,
  input  logic [DWIDTH-1:0] mem_rdata,
  input  logic              mem_rvalid,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              halted,
  output logic [2:0]        fault
);
  import bf_pkg::*;

  localparam logic [PWIDTH-1:0] PcOne  = 1;
  localparam logic [PWIDTH-1:0] PcMax  = '1;
  localparam logic [AWIDTH-1:0] AdrOne = 1;
  localparam logic [AWIDTH-1:0] AdrMax = '1;
  localparam logic [DWIDTH-1:0] DatOne = 1;
  localparam logic [DWIDTH-1:0] DatMax = '1;

  state_e            state_q, state_d;
  logic [PWIDTH-1:0] pc_q, pc_d;
  logic [AWIDTH-1:0] dp_q, dp_d;
  logic [DWIDTH-1:0] dat_q, dat_d;
  logic              dirty_q, dirty_d;
  logic [PWIDTH-1:0] depth_q, depth_d;
  logic [7:0]        ir_q, ir_d;
  fault_e            fault_q, fault_d;
  logic [AWIDTH-1:0] clr_q, clr_d;
  logic              rd_pend_q, rd_pend_d;

  logic              stk_push, stk_pop, stk_clr, stk_full, stk_empty;
  logic [PWIDTH-1:0] stk_top;

  logic [PWIDTH-1:0] pc_inc;
  state_e            adv_state, skip_state;
  logic [AWIDTH-1:0] dp_step;
  logic              ptr_oob;
  logic [DWIDTH-1:0] dat_inc, dat_dec;

  assign pc_inc     = pc_q + PcOne;
  assign adv_state  = (pc_inc == PcMax) ? StFlush : StFetch;
  assign skip_state = (pc_inc == PcMax) ? StFlush : StSkip;
  assign dp_step    = (ir_q == OpRight) ? dp_q + AdrOne : dp_q - AdrOne;
  assign ptr_oob    = (ir_q == OpRight) ? (dp_q == AdrMax) : (dp_q == '0);
  assign dat_inc    = (CELL_MODE == 1 && dat_q == DatMax) ? dat_q : dat_q + DatOne;
  assign dat_dec    = (CELL_MODE == 1 && dat_q == '0) ? dat_q : dat_q - DatOne;

  assign pc       = pc_q;
  assign out_data = 8'(dat_q);
  assign busy     = (state_q != StIdle) && (state_q != StHalt);
  assign halted   = (state_q == StHalt);
  assign fault    = fault_q;

  bf_loop_stack #(
    .SDEPTH(SDEPTH),
    .PWIDTH(PWIDTH)
  ) u_stack (
    .clk  (clk),
    .rst  (rst),
    .clr  (stk_clr),
    .push (stk_push),
    .pop  (stk_pop),
    .din  (pc_inc),
    .top  (stk_top),
    .full (stk_full),
    .empty(stk_empty)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    dp_d      = dp_q;
    dat_d     = dat_q;
    dirty_d   = dirty_q;
    depth_d   = depth_q;
    ir_d      = ir_q;
    fault_d   = fault_q;
    clr_d     = clr_q;
    rd_pend_d = rd_pend_q;
    stk_push  = 1'b0;
    stk_pop   = 1'b0;
    stk_clr   = 1'b0;
    op_req    = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = dat_q;
    mem_re    = 1'b0;
    dp_adr    = dp_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    case (state_q)
      StIdle, StHalt: begin
        if (start) begin
          pc_d      = '0;
          dp_d      = '0;
          dat_d     = '0;
          dirty_d   = 1'b0;
          depth_d   = '0;
          fault_d   = FaultNone;
          clr_d     = '0;
          rd_pend_d = 1'b0;
          stk_clr   = 1'b1;
          state_d   = (CLEAR_EN != 0) ? StClear : StFetch;
        end
      end
      StClear: begin
        mem_we    = 1'b1;
        mem_wdata = '0;
        dp_adr    = clr_q;
        clr_d     = clr_q + AdrOne;
        if (clr_q == AdrMax) state_d = StFetch;
      end
      StFetch: begin
        op_req = 1'b1;
        if (op_valid) begin
          ir_d    = op_data;
          state_d = StExec;
        end
      end
      StExec: begin
        case (ir_q)
          OpInc, OpDec: begin
            dat_d   = (ir_q == OpInc) ? dat_inc : dat_dec;
            dirty_d = 1'b1;
            pc_d    = pc_inc;
            state_d = adv_state;
          end
          OpRight, OpLeft: begin
            if (PTR_MODE == 1 && ptr_oob) begin
              fault_d = FaultPtr;
              state_d = StFlush;
            end else if (dirty_q) begin
              state_d = StWb;
            end else begin
              dp_d      = dp_step;
              rd_pend_d = 1'b0;
              state_d   = StRd;
            end
          end
          OpOut: state_d = StOut;
          OpIn:  state_d = StIn;
          OpOpen: begin
            if (dat_q != '0) begin
              if (stk_full) begin
                fault_d = FaultOverflow;
                state_d = StFlush;
              end else begin
                stk_push = 1'b1;
                pc_d     = pc_inc;
                state_d  = adv_state;
              end
            end else begin
              depth_d = '0;
              pc_d    = pc_inc;
              state_d = skip_state;
            end
          end
          OpClose: begin
            if (stk_empty) begin
              fault_d = FaultUnderflow;
              state_d = StFlush;
            end else if (dat_q != '0) begin
              // Loop back to the body start; the entry stays for the next pass.
              pc_d    = stk_top;
              state_d = (stk_top == PcMax) ? StFlush : StFetch;
            end else begin
              stk_pop = 1'b1;
              pc_d    = pc_inc;
              state_d = adv_state;
            end
          end
          OpEnd: state_d = StFlush;
          default: begin
            pc_d    = pc_inc;
            state_d = adv_state;
          end
        endcase
      end
      StWb: begin
        mem_we    = 1'b1;
        dirty_d   = 1'b0;
        dp_d      = dp_step;
        rd_pend_d = 1'b0;
        state_d   = StRd;
      end
      StRd: begin
        if (!rd_pend_q) begin
          mem_re    = 1'b1;
          rd_pend_d = 1'b1;
        end else if (mem_rvalid) begin
          dat_d     = mem_rdata;
          rd_pend_d = 1'b0;
          pc_d      = pc_inc;
          state_d   = adv_state;
        end
      end
      StIn: begin
        in_ready = 1'b1;
        if (in_valid) begin
          dat_d   = DWIDTH'(in_data);
          dirty_d = 1'b1;
          pc_d    = pc_inc;
          state_d = adv_state;
        end
      end
      StOut: begin
        out_valid = 1'b1;
        if (out_ready) begin
          pc_d    = pc_inc;
          state_d = adv_state;
        end
      end
      StSkip: begin
        op_req = 1'b1;
        if (op_valid) begin
          pc_d = pc_inc;
          case (op_data)
            OpOpen: begin
              depth_d = depth_q + PcOne;
              state_d = skip_state;
            end
            OpClose: begin
              if (depth_q == '0) begin
                state_d = adv_state;
              end else begin
                depth_d = depth_q - PcOne;
                state_d = skip_state;
              end
            end
            OpEnd: begin
              pc_d    = pc_q;
              fault_d = FaultUnmatched;
              state_d = StFlush;
            end
            default: state_d = skip_state;
          endcase
        end
      end
      StFlush: begin
        mem_we  = dirty_q;
        dirty_d = 1'b0;
        state_d = StHalt;
      end
      default: state_d = StIdle;
    endcase

    // Synchronous reset wins over everything, including an in-flight handshake.
    if (s_rst) begin
      state_d   = StIdle;
      pc_d      = '0;
      dp_d      = '0;
      dat_d     = '0;
      dirty_d   = 1'b0;
      depth_d   = '0;
      ir_d      = '0;
      fault_d   = FaultNone;
      clr_d     = '0;
      rd_pend_d = 1'b0;
      stk_push  = 1'b0;
      stk_pop   = 1'b0;
      stk_clr   = 1'b1;
      op_req    = 1'b0;
      mem_we    = 1'b0;
      mem_re    = 1'b0;
      in_ready  = 1'b0;
      out_valid = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      pc_q      <= '0;
      dp_q      <= '0;
      dat_q     <= '0;
      dirty_q   <= 1'b0;
      depth_q   <= '0;
      ir_q      <= '0;
      fault_q   <= FaultNone;
      clr_q     <= '0;
      rd_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      dp_q      <= dp_d;
      dat_q     <= dat_d;
      dirty_q   <= dirty_d;
      depth_q   <= depth_d;
      ir_q      <= ir_d;
      fault_q   <= fault_d;
      clr_q     <= clr_d;
      rd_pend_q <= rd_pend_d;
    end
  end

endmodule

// File: tb/tb_bf_core_v2.sv
// Scoreboard bench: instance 0 uses default modes, instance 1 saturates, faults on
// pointer range and has a two-entry loop stack.
module tb_bf_core_v2;

  localparam int AW = 4;
  localparam int PW = 8;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic s_rst = 1'b0;
  logic ph = 1'b0;
  logic op_slow;
  logic fill;
  int   rd_lat;

  logic [7:0]    in_data;
  logic          in_valid;
  logic          out_ready;

  logic          start      [2];
  logic [PW-1:0] pc         [2];
  logic          op_req     [2];
  logic [7:0]    op_data    [2];
  logic          op_valid   [2];
  logic [AW-1:0] dp_adr     [2];
  logic          mem_we     [2];
  logic [DW-1:0] mem_wdata  [2];
  logic          mem_re     [2];
  logic [DW-1:0] mem_rdata  [2];
  logic          mem_rvalid [2];
  logic          in_ready   [2];
  logic [7:0]    out_data   [2];
  logic          out_valid  [2];
  logic          busy       [2];
  logic          halted     [2];
  logic [2:0]    fault      [2];

  logic [7:0]    prog [256];
  logic [7:0]    dmem [2][16];
  logic [AW-1:0] rd_adr [2];
  int            rd_cnt [2];
  int            rd_count [2];

  logic [7:0] exp_out [$];
  int         exp_fault [$];
  int         total = 0;
  int         bad = 0;
  int         cyc;
  int         n;
  logic [1:0] hprev;

  always #5 clk = ~clk;
  always @(posedge clk) ph <= ~ph;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    assign op_data[g]  = prog[pc[g]];
    assign op_valid[g] = op_req[g] & (ph | ~op_slow);

    bf_core_v2 #(
      .AWIDTH   (AW),
      .DWIDTH   (DW),
      .PWIDTH   (PW),
      .SDEPTH   ((g == 0) ? 4 : 1),
      .CELL_MODE(g),
      .PTR_MODE (g),
      .CLEAR_EN (1)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .s_rst     (s_rst),
      .start     (start[g]),
      .pc        (pc[g]),
      .op_req    (op_req[g]),
      .op_data   (op_data[g]),
      .op_valid  (op_valid[g]),
      .dp_adr    (dp_adr[g]),
      .mem_we    (mem_we[g]),
      .mem_wdata (mem_wdata[g]),
      .mem_re    (mem_re[g]),
      .mem_rdata (mem_rdata[g]),
      .mem_rvalid(mem_rvalid[g]),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready[g]),
      .out_data  (out_data[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready),
      .busy      (busy[g]),
      .halted    (halted[g]),
      .fault     (fault[g])
    );
  end

  // Data SRAM model with a programmable read latency.
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      mem_rvalid[g] <= 1'b0;
      if (fill) begin
        for (int i = 0; i < 16; i++) dmem[g][i] <= 8'hAA;
      end else if (mem_we[g] === 1'b1) begin
        dmem[g][dp_adr[g]] <= mem_wdata[g];
      end
      if (mem_re[g] === 1'b1) begin
        rd_cnt[g]   <= rd_lat;
        rd_adr[g]   <= dp_adr[g];
        rd_count[g] <= rd_count[g] + 1;
      end else if (rd_cnt[g] == 1) begin
        mem_rvalid[g] <= 1'b1;
        mem_rdata[g]  <= dmem[g][rd_adr[g]];
        rd_cnt[g]     <= 0;
      end else if (rd_cnt[g] > 1) begin
        rd_cnt[g] <= rd_cnt[g] - 1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_unexpected(input string name, input logic [31:0] act);
    total++;
    bad++;
    $display("FAIL %s: got 0x%0h expected nothing", name, act);
  endtask

  // Monitor: pops the scoreboard on every output transfer and every halt.
  initial begin
    hprev = 2'b00;
    forever begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        if (out_valid[g] === 1'b1 && out_ready === 1'b1) begin
          if (exp_out.size() == 0) fail_unexpected("unexpected_out", 32'(out_data[g]));
          else check("out_data", 32'(out_data[g]), 32'(exp_out.pop_front()));
        end
        if (halted[g] === 1'b1 && !hprev[g]) begin
          if (exp_fault.size() == 0) fail_unexpected("unexpected_halt", 32'(fault[g]));
          else check("fault", 32'(fault[g]), exp_fault.pop_front());
        end
        hprev[g] = (halted[g] === 1'b1);
      end
    end
  end

  task automatic load(input string p);
    for (int i = 0; i < 256; i++) prog[i] = 8'h00;
    for (int i = 0; i < p.len(); i++) prog[i] = p[i];
  endtask

  task automatic launch(input int g);
    start[g] = 1'b1;
    @(posedge clk);
    #1;
    start[g] = 1'b0;
  endtask

  task automatic wait_halt(input int g, input string name);
    int c = 0;
    while (halted[g] !== 1'b1 && c < 4000) begin
      @(posedge clk);
      #1;
      c++;
    end
    check({name, "_halt"}, 32'(halted[g]), 1);
    @(negedge clk);
    #1;
    check({name, "_drained"}, exp_out.size() + exp_fault.size(), 0);
  endtask

  task automatic run(input int g, input string p, input int f);
    load(p);
    exp_fault.push_back(f);
    launch(g);
    wait_halt(g, p);
  endtask

  task automatic wait_out_valid(input int g);
    cyc = 0;
    while (out_valid[g] !== 1'b1 && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  initial begin
    start[0] = 1'b0;
    start[1] = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    out_ready = 1'b1;
    op_slow = 1'b0;
    rd_lat = 1;
    fill = 1'b1;
    load("");
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy[0]), 0);
    check("rst_pc", 32'(pc[0]), 0);
    check("rst_mem_we", 32'(mem_we[0]), 0);
    check("rst_out_valid", 32'(out_valid[0]), 0);
    rst = 1'b1;
    fill = 1'b0;
    @(posedge clk);
    #1;
    check("idle_halted", 32'(halted[0]), 0);
    check("idle_fault", 32'(fault[0]), 0);
    check("idle_op_req", 32'(op_req[0]), 0);

    load("+++.");
    exp_out.push_back(8'h03);
    exp_fault.push_back(0);
    launch(0);
    check("clear_we", 32'(mem_we[0]), 1);
    check("clear_busy", 32'(busy[0]), 1);
    wait_halt(0, "inc3");
    check("inc3_busy", 32'(busy[0]), 0);
    check("clear_cell5", 32'(dmem[0][5]), 0);
    check("flush_cell0", 32'(dmem[0][0]), 3);

    exp_out.push_back(8'hFF);
    run(0, "-.", 0);
    exp_out.push_back(8'h00);
    run(1, "-.", 0);

    rd_lat = 3;
    op_slow = 1'b1;
    exp_out.push_back(8'h06);
    run(0, "++[>+++<-]>.", 0);
    check("loop_cell0", 32'(dmem[0][0]), 0);
    check("loop_cell1", 32'(dmem[0][1]), 6);
    rd_lat = 1;
    op_slow = 1'b0;

    exp_out.push_back(8'h01);
    run(0, "[+++]+.", 0);
    exp_out.push_back(8'h01);
    run(0, "[[]+]+.", 0);
    run(0, "[", 4);

    run(1, "+[[[", 1);
    run(1, "+]", 2);
    n = rd_count[1];
    run(1, "<", 3);
    check("ptr_no_re", rd_count[1] - n, 0);

    // Stalled input then stalled output.
    load(",.");
    out_ready = 1'b0;
    exp_fault.push_back(0);
    exp_out.push_back(8'h41);
    launch(0);
    cyc = 0;
    while (in_ready[0] !== 1'b1 && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    for (int k = 0; k < 5; k++) begin
      check("in_ready_held", 32'(in_ready[0]), 1);
      @(posedge clk);
      #1;
    end
    in_data = 8'h41;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data = 8'h00;
    check("in_ready_drop", 32'(in_ready[0]), 0);
    wait_out_valid(0);
    for (int k = 0; k < 3; k++) begin
      check("out_hold_valid", 32'(out_valid[0]), 1);
      check("out_hold_data", 32'(out_data[0]), 32'h41);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    wait_halt(0, "io");

    // Synchronous reset in the middle of an output stall.
    load("+.");
    out_ready = 1'b0;
    launch(0);
    wait_out_valid(0);
    check("srst_pre_valid", 32'(out_valid[0]), 1);
    s_rst = 1'b1;
    @(posedge clk);
    #1;
    check("srst_out_valid", 32'(out_valid[0]), 0);
    check("srst_busy", 32'(busy[0]), 0);
    check("srst_halted", 32'(halted[0]), 0);
    check("srst_pc", 32'(pc[0]), 0);
    s_rst = 1'b0;
    out_ready = 1'b1;
    exp_out.push_back(8'h03);
    run(0, "+++.", 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bf_core_v2.md
Name: bf_core_v2

Overview:
- Second-generation Brainfuck execution core: sequential fetch/execute engine with parametrised cell width, stack depth and arithmetic/pointer modes.
- Adds valid/ready stall handshakes on program fetch, data read and byte I/O, a write-back cell cache, and fault reporting.
- Sits between the program ROM, the data SRAM and the host byte streams.

Parameters:
- AWIDTH, 12: data address bits.
- DWIDTH, 8: cell width.
- PWIDTH, 12: program counter bits; byte-addressed, one opcode per address.
- SDEPTH, 4: loop stack holds 2^SDEPTH entries.
- CELL_MODE, 0: 0 = wrap on +/-, 1 = saturate at 0 and 2^DWIDTH-1.
- PTR_MODE, 0: 0 = dp wraps, 1 = dp under/overflow is a fault.
- CLEAR_EN, 1: 1 = zero all data memory on start.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- s_rst  in  1  synchronous reset, active-high.
- start  in  1  begin run; honoured only when busy=0.
- pc  out  PWIDTH  program address.
- op_req  out  1  fetch request.
- op_data  in  8  opcode byte.
- op_valid  in  1  op_data valid; sampled only while op_req=1.
- dp_adr  out  AWIDTH  data address.
- mem_we  out  1  one-cycle write strobe, always accepted.
- mem_wdata  out  DWIDTH  write data.
- mem_re  out  1  one-cycle read strobe.
- mem_rdata  in  DWIDTH  read data.
- mem_rvalid  in  1  mem_rdata valid, at least 1 cycle after mem_re.
- in_data  in  8  input byte.
- in_valid  in  1  input available.
- in_ready  out  1  core accepts input.
- out_data  out  8  output byte.
- out_valid  out  1  output available.
- out_ready  in  1  sink accepts output.
- busy  out  1  run in progress.
- halted  out  1  run ended.
- fault  out  3  0 = none, 1 = stack overflow, 2 = stack underflow, 3 = pointer range, 4 = unmatched '['.

Behaviour:
- Reset values: rst low or s_rst high forces state IDLE. All of the following clear to 0: outputs, pc, dp, sp, dat, dirty, depth. s_rst is lowest-latency priority, overriding start and all handshakes, including mid-transfer.
- Opcodes: 2B +, 2D -, 3E >, 3C <, 2E ., 2C ,, 5B [, 5D ], 00 end-of-program. All other bytes are NOP.
- IDLE, or HALT with start=1:
  - Clear pc, dp, sp, dat, dirty, halted and fault.
  - Go to CLEAR if CLEAR_EN=1, else FETCH.
- CLEAR: mem_we=1, mem_wdata=0, dp_adr counting 0..2^AWIDTH-1 (2^AWIDTH cycles), then FETCH with dp_adr=0.
- FETCH: op_req=1 with pc held stable until op_valid=1, then latch IR and go to EXEC. Minimum instruction time is 2 cycles (FETCH+EXEC).
- EXEC, per opcode:
  - + / -: dat ±1 (CELL_MODE rules), dirty=1, pc+1.
  - > / <:
    - If PTR_MODE=1 and dp would leave 0..2^AWIDTH-1: fault=3, go to FLUSH.
    - Else if dirty: WB (mem_we at old dp, dirty=0).
    - Then RD: dp±1, mem_re pulse, wait mem_rvalid, dat<=mem_rdata. pc+1.
  - .: OUT state, out_valid=1, out_data=dat[7:0] held stable until out_ready. Then pc+1.
  - ,: IN state, in_ready=1 until in_valid. Then dat<=zero-extended in_data, dirty=1, pc+1.
  - [ with dat≠0: push pc+1 (stack full → fault=1, FLUSH). pc+1.
  - [ with dat=0: SKIP with depth=0, pc+1.
  - ] with dat≠0: pc<=top of stack, no pop (stack empty → fault=2).
  - ] with dat=0: pop (empty → fault=2). pc+1.
  - 00: FLUSH.
  - pc reaching 2^PWIDTH-1 after execution: FLUSH.
- SKIP: one opcode per fetch.
  - '[': depth+1.
  - ']' with depth=0: leave SKIP, pc+1, go to FETCH.
  - ']' otherwise: depth-1.
  - 00: fault=4, FLUSH.
- FLUSH: if dirty, one mem_we of dat at dp. Then HALT.
- HALT: halted=1, busy=0. fault holds until the next start.
- busy=1 in every state except IDLE/HALT. start is ignored while busy.
- out_valid never drops without out_ready. in_ready never drops without in_valid, except on reset.

Decomposition:
- bf_pkg holds the opcode byte constants, the state enum (IDLE, CLEAR, FETCH, EXEC, WB, RD, IN, OUT, SKIP, FLUSH, HALT) and the fault codes.
- Sub-module bf_loop_stack, parameters SDEPTH and PWIDTH:
  - Inputs push, pop, din; outputs top, full, empty.
  - Synchronous; push and pop asserted together is illegal and asserted against.

Test Plan:
- "+++." then 00, out_ready=1 → exactly one out_data=03 transfer, then halted=1, fault=0.
- "-." with CELL_MODE=0 → out 0xFF. Same program with CELL_MODE=1 → out 0x00.
- "++[>+++<-]>." with mem_rvalid latency 3 → out 06; final memory cell0=0, cell1=06 after flush.
- "[+++]+." and "[[]+]+." on zero cell → both output 01; "[" followed by 00 → fault=4.
- SDEPTH=1: "+[[[" → fault=1 on the third '['. "+]" → fault=2. PTR_MODE=1 "<" → fault=3 with no mem_re issued.
- ",." with in_valid delayed 5 cycles (in_data=41) and out_ready low 3 cycles → in_ready held 5 cycles, out_valid held with 41 stable, one transfer each. s_rst mid-OUT → out_valid=0 next cycle, state IDLE.
